// File: rtl/riscv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pipe_pkg
// Definitions shared by the MEM-stage controller and its MEM/WB register:
//   mem_state_t     - bus-handshake FSM state (IDLE, BUSY)
//   XLEN_DEFAULT    - default data/address width
//   TIMEOUT_DEFAULT - default number of BUSY cycles before a bus timeout
//   ALIGN_MASK      - low address bits that must be zero for a word access
//   is_misaligned() - word-alignment test on the low address bits
// -----------------------------------------------------------------------------
package riscv_pipe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    localparam int         XLEN_DEFAULT    = 32;
    localparam int         TIMEOUT_DEFAULT = 16;
    localparam logic [1:0] ALIGN_MASK      = 2'b11;

    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return (addr_lo & ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/mem_wb.sv
// -----------------------------------------------------------------------------
// mem_wb
// MEM/WB pipeline register feeding write-back.
//   clk, reset       - clock, asynchronous active-high reset
//   i_bubble         - clear the control bits and hold the data fields
//   i_rdata_en       - a load completes this cycle; capture i_rdata
//   i_alu_result,
//   i_rd, i_reg_write,
//   i_mem_to_reg     - EX/MEM values captured on a normal cycle
//   i_rdata          - load data from the data-memory bus
//   o_*              - registered MEM/WB outputs
// -----------------------------------------------------------------------------
module mem_wb
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_bubble,
    input  logic            i_rdata_en,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_rdata,
    input  logic [4:0]      i_rd,
    input  logic            i_reg_write,
    input  logic            i_mem_to_reg,
    output logic [XLEN-1:0] o_read_data,
    output logic [XLEN-1:0] o_alu_result,
    output logic [4:0]      o_rd,
    output logic            o_reg_write,
    output logic            o_mem_to_reg
);

    logic [XLEN-1:0] r_read_data;
    logic [XLEN-1:0] r_alu_result;
    logic [4:0]      r_rd;
    logic            r_reg_write;
    logic            r_mem_to_reg;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the reset is in the sensitivity list, making it
    // asynchronous, and every register here has a defined reset value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else if (i_bubble) begin
            // Only the control bits are squashed; data fields keep their value.
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
        end else begin
            r_alu_result <= i_alu_result;
            r_rd         <= i_rd;
            r_reg_write  <= i_reg_write;
            r_mem_to_reg <= i_mem_to_reg;
            if (i_rdata_en) begin
                r_read_data <= i_rdata;
            end
        end
    end

    assign o_read_data  = r_read_data;
    assign o_alu_result = r_alu_result;
    assign o_rd         = r_rd;
    assign o_reg_write  = r_reg_write;
    assign o_mem_to_reg = r_mem_to_reg;

endmodule

// File: rtl/mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// mem_stage_ctrl
// MEM-stage controller: drives the data-memory req/ready bus from the EX/MEM
// register, stalls upstream during wait states, resolves branches, turns
// misaligned/failed accesses into bubbles, and holds the MEM/WB register.
//   clk, reset                      - clock, asynchronous active-high reset
//   alu_result, write_data, rd,
//   zero, pc_branch, reg_write,
//   mem_read, mem_write,
//   mem_to_reg, branch              - EX/MEM register outputs
//   dmem_req/we/addr/wdata          - data-memory request (to slave)
//   dmem_ready/rdata/err            - data-memory response (from slave)
//   stall                           - freeze PC, IF/ID, ID/EX, EX/MEM
//   pc_src, pc_target               - branch decision and target
//   wb_*                            - MEM/WB register outputs
//   exc_misalign, exc_bus           - one-cycle exception pulses
// -----------------------------------------------------------------------------
module mem_stage_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] write_data,
    input  logic [4:0]      rd,
    input  logic            zero,
    input  logic [XLEN-1:0] pc_branch,
    input  logic            reg_write,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            mem_to_reg,
    input  logic            branch,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ready,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_err,
    output logic            stall,
    output logic            pc_src,
    output logic [XLEN-1:0] pc_target,
    output logic [XLEN-1:0] wb_read_data,
    output logic [XLEN-1:0] wb_alu_result,
    output logic [4:0]      wb_rd,
    output logic            wb_reg_write,
    output logic            wb_mem_to_reg,
    output logic            exc_misalign,
    output logic            exc_bus
);

    // A disabled timeout still needs a 1-bit counter to keep widths legal.
    localparam int              CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'((TIMEOUT > 0) ? 1 : 0);

    mem_state_t       r_state;
    mem_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;

    logic w_access;
    logic w_misaligned;
    logic w_req;
    logic w_done;
    logic w_timeout;
    logic w_stall;
    logic w_exc_bus;
    logic w_exc_misalign;
    logic w_bubble;
    logic w_rdata_en;

    assign w_access     = mem_read | mem_write;
    assign w_misaligned = w_access & is_misaligned(alu_result[1:0]);
    // Reset gates the request so an in-flight access is abandoned at once.
    assign w_req        = w_access & ~w_misaligned & ~reset;
    assign w_done       = w_req & dmem_ready;
    assign w_timeout    = (TIMEOUT != 0) && (r_state == BUSY) && (r_wait_cnt == CNT_MAX);

    // State register and wait counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next-state logic.
    // NOTE: every signal assigned in a combinational block gets a default at
    // the top so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        case (r_state)
            IDLE: begin
                if (w_req && !dmem_ready) begin
                    w_state_nxt    = BUSY;
                    w_wait_cnt_nxt = CNT_ONE;
                end
            end
            BUSY: begin
                // Dropping the request is not expected while stalled, but
                // returning to IDLE keeps the FSM from hanging if it happens.
                if (!w_req || dmem_ready || w_timeout) begin
                    w_state_nxt    = IDLE;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt != CNT_MAX) begin
                    w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt    = IDLE;
                w_wait_cnt_nxt = '0;
            end
        endcase
    end

    // Output logic. The same expressions hold in IDLE and BUSY; w_timeout can
    // only be set in BUSY, and dmem_ready beats a coincident timeout.
    always_comb begin
        w_stall        = 1'b0;
        w_exc_bus      = 1'b0;
        w_exc_misalign = 1'b0;
        w_bubble       = 1'b0;
        w_rdata_en     = 1'b0;

        w_stall        = w_req & ~dmem_ready & ~w_timeout;
        w_exc_bus      = (w_done & dmem_err) | (w_timeout & ~dmem_ready);
        w_exc_misalign = w_misaligned & ~reset;
        w_bubble       = w_stall | w_exc_bus | w_exc_misalign;
        w_rdata_en     = w_done & mem_read;
    end

    mem_wb #(
        .XLEN (XLEN)
    ) u_mem_wb (
        .clk          (clk),
        .reset        (reset),
        .i_bubble     (w_bubble),
        .i_rdata_en   (w_rdata_en),
        .i_alu_result (alu_result),
        .i_rdata      (dmem_rdata),
        .i_rd         (rd),
        .i_reg_write  (reg_write),
        .i_mem_to_reg (mem_to_reg),
        .o_read_data  (wb_read_data),
        .o_alu_result (wb_alu_result),
        .o_rd         (wb_rd),
        .o_reg_write  (wb_reg_write),
        .o_mem_to_reg (wb_mem_to_reg)
    );

    assign dmem_req     = w_req;
    assign dmem_we      = mem_write;
    assign dmem_addr    = alu_result;
    assign dmem_wdata   = write_data;
    assign stall        = w_stall;
    assign pc_src       = branch & zero;
    assign pc_target    = pc_branch;
    assign exc_misalign = w_exc_misalign;
    assign exc_bus      = w_exc_bus;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_ctrl
// Directed bench for mem_stage_ctrl (TIMEOUT=4): single-cycle vector table
// followed by multi-cycle sequences for wait states, timeout and async reset.
// -----------------------------------------------------------------------------
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result, write_data, pc_branch, dmem_rdata;
    logic [4:0]  rd;
    logic        zero, reg_write, mem_read, mem_write, mem_to_reg, branch;
    logic        dmem_ready, dmem_err;
    logic        dmem_req, dmem_we, stall, pc_src;
    logic [31:0] dmem_addr, dmem_wdata, pc_target, wb_read_data, wb_alu_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_write, wb_mem_to_reg, exc_misalign, exc_bus;

    int n_cmp = 0;
    int n_err = 0;

    mem_stage_ctrl #(
        .XLEN    (32),
        .TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .alu_result    (alu_result),
        .write_data    (write_data),
        .rd            (rd),
        .zero          (zero),
        .pc_branch     (pc_branch),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_to_reg    (mem_to_reg),
        .branch        (branch),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_ready    (dmem_ready),
        .dmem_rdata    (dmem_rdata),
        .dmem_err      (dmem_err),
        .stall         (stall),
        .pc_src        (pc_src),
        .pc_target     (pc_target),
        .wb_read_data  (wb_read_data),
        .wb_alu_result (wb_alu_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_mem_to_reg (wb_mem_to_reg),
        .exc_misalign  (exc_misalign),
        .exc_bus       (exc_bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic        zero;
        logic [31:0] pcb;
        logic [4:0]  ctrl;    // {reg_write, mem_read, mem_write, mem_to_reg, branch}
        logic        rdy;
        logic        err;
        logic [31:0] rdata;
        logic [5:0]  e_comb;  // {req, we, stall, pc_src, exc_misalign, exc_bus}
        logic        e_rw;
        logic        e_m2r;
        logic [4:0]  e_rd;
        logic [31:0] e_alu;
        logic [31:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(
        input logic [31:0] alu, input logic [31:0] wdata, input logic [4:0] r,
        input logic z, input logic [31:0] pcb, input logic [4:0] ctrl,
        input logic rdy, input logic err, input logic [31:0] rdata,
        input logic [5:0] e_comb, input logic e_rw, input logic e_m2r,
        input logic [4:0] e_rd, input logic [31:0] e_alu, input logic [31:0] e_rdata);
        vec_t v;
        v.alu = alu;  v.wdata = wdata; v.rd = r; v.zero = z; v.pcb = pcb;
        v.ctrl = ctrl; v.rdy = rdy; v.err = err; v.rdata = rdata;
        v.e_comb = e_comb; v.e_rw = e_rw; v.e_m2r = e_m2r; v.e_rd = e_rd;
        v.e_alu = e_alu; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        alu_result = '0; write_data = '0; rd = '0; zero = 1'b0; pc_branch = '0;
        reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_to_reg = 1'b0;
        branch = 1'b0; dmem_ready = 1'b0; dmem_rdata = '0; dmem_err = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        alu_result = v.alu; write_data = v.wdata; rd = v.rd; zero = v.zero;
        pc_branch = v.pcb;
        {reg_write, mem_read, mem_write, mem_to_reg, branch} = v.ctrl;
        dmem_ready = v.rdy; dmem_err = v.err; dmem_rdata = v.rdata;
    endtask

    task automatic check_wb_zero(input string tag);
        check({tag, " wb_read_data"},  wb_read_data,  32'h0);
        check({tag, " wb_alu_result"}, wb_alu_result, 32'h0);
        check({tag, " wb_rd"},         wb_rd,         32'h0);
        check({tag, " wb_reg_write"},  wb_reg_write,  32'h0);
        check({tag, " wb_mem_to_reg"}, wb_mem_to_reg, 32'h0);
    endtask

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ctrl = {rw, mr, mw, m2r, br}; e_comb = {req, we, stall, pc_src, mis, bus}
        vecs[0] = mk(32'h10,  0, 3,  0, 0,     5'b10000, 0, 0, 0,            6'b000000, 1, 0, 3,  32'h10,  32'h0);
        vecs[1] = mk(32'h100, 0, 5,  0, 0,     5'b11010, 1, 0, 32'hDEADBEEF, 6'b100000, 1, 1, 5,  32'h100, 32'hDEADBEEF);
        vecs[2] = mk(32'h204, 32'h55, 0, 0, 0, 5'b00100, 1, 0, 0,            6'b110000, 0, 0, 0,  32'h204, 32'hDEADBEEF);
        vecs[3] = mk(32'h102, 0, 7,  0, 0,     5'b11010, 1, 0, 32'h11111111, 6'b000010, 0, 0, 0,  32'h204, 32'hDEADBEEF);
        vecs[4] = mk(32'h300, 0, 9,  0, 0,     5'b11010, 1, 1, 32'h22222222, 6'b100001, 0, 0, 0,  32'h204, 32'hDEADBEEF);
        vecs[5] = mk(32'h44,  0, 0,  1, 32'h80, 5'b00001, 0, 0, 0,           6'b000100, 0, 0, 0,  32'h44,  32'hDEADBEEF);
        vecs[6] = mk(32'h48,  0, 2,  0, 32'h90, 5'b10001, 0, 0, 0,           6'b000000, 1, 0, 2,  32'h48,  32'hDEADBEEF);
        vecs[7] = mk(32'h201, 32'h77, 4, 0, 0, 5'b00100, 1, 0, 0,            6'b010010, 0, 0, 2,  32'h48,  32'hDEADBEEF);
        vecs[8] = mk(32'h1FC, 0, 31, 0, 0,     5'b11010, 1, 0, 32'hCAFEF00D, 6'b100000, 1, 1, 31, 32'h1FC, 32'hCAFEF00D);

        // Reset state.
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset dmem_req", dmem_req, 32'h0);
        check("reset stall", stall, 32'h0);
        check("reset exc_misalign", exc_misalign, 32'h0);
        check("reset exc_bus", exc_bus, 32'h0);
        check_wb_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single-cycle vectors, all completing from IDLE.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d dmem_req", i),     dmem_req,     vecs[i].e_comb[5]);
            check($sformatf("v%0d dmem_we", i),      dmem_we,      vecs[i].e_comb[4]);
            check($sformatf("v%0d stall", i),        stall,        vecs[i].e_comb[3]);
            check($sformatf("v%0d pc_src", i),       pc_src,       vecs[i].e_comb[2]);
            check($sformatf("v%0d exc_misalign", i), exc_misalign, vecs[i].e_comb[1]);
            check($sformatf("v%0d exc_bus", i),      exc_bus,      vecs[i].e_comb[0]);
            check($sformatf("v%0d pc_target", i),    pc_target,    vecs[i].pcb);
            check($sformatf("v%0d dmem_addr", i),    dmem_addr,    vecs[i].alu);
            check($sformatf("v%0d dmem_wdata", i),   dmem_wdata,   vecs[i].wdata);
            @(posedge clk);
            #1;
            check($sformatf("v%0d wb_reg_write", i),  wb_reg_write,  vecs[i].e_rw);
            check($sformatf("v%0d wb_mem_to_reg", i), wb_mem_to_reg, vecs[i].e_m2r);
            check($sformatf("v%0d wb_rd", i),         wb_rd,         vecs[i].e_rd);
            check($sformatf("v%0d wb_alu_result", i), wb_alu_result, vecs[i].e_alu);
            check($sformatf("v%0d wb_read_data", i),  wb_read_data,  vecs[i].e_rdata);
        end

        // Store with three wait states: ready rises in the fourth cycle.
        @(negedge clk);
        clear_inputs();
        mem_write = 1'b1; alu_result = 32'h200; write_data = 32'h1234;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            dmem_ready = (k == 3);
            #1;
            check($sformatf("store c%0d dmem_req", k), dmem_req, 32'h1);
            check($sformatf("store c%0d dmem_we", k),  dmem_we,  32'h1);
            check($sformatf("store c%0d stall", k),    stall,    (k < 3) ? 32'h1 : 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("store c%0d wb_reg_write", k), wb_reg_write, 32'h0);
        end
        check("store wb_alu_result", wb_alu_result, 32'h200);

        // Load timing out: four stall cycles, then a one-cycle exc_bus.
        @(negedge clk);
        clear_inputs();
        mem_read = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1; rd = 5'd6;
        alu_result = 32'h400; dmem_rdata = 32'h33333333;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            check($sformatf("timeout c%0d stall", k),   stall,   (k < 4) ? 32'h1 : 32'h0);
            check($sformatf("timeout c%0d exc_bus", k), exc_bus, (k == 4) ? 32'h1 : 32'h0);
            @(posedge clk);
            #1;
            check($sformatf("timeout c%0d wb_reg_write", k), wb_reg_write, 32'h0);
        end
        check("timeout wb_alu_result hold", wb_alu_result, 32'h200);
        check("timeout wb_read_data hold",  wb_read_data,  32'hCAFEF00D);

        // Back in IDLE: a fresh wait-stated load stalls without a timeout.
        @(negedge clk);
        #1;
        check("post-timeout stall", stall, 32'h1);
        check("post-timeout exc_bus", exc_bus, 32'h0);
        @(posedge clk);

        // Reset while BUSY: request and stall drop immediately.
        #2;
        reset = 1'b1;
        #1;
        check("midreset dmem_req", dmem_req, 32'h0);
        check("midreset stall", stall, 32'h0);
        check_wb_zero("midreset");
        @(negedge clk);
        clear_inputs();
        reset = 1'b0;

        // Normal zero-wait load after reset.
        @(negedge clk);
        mem_read = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1; rd = 5'd8;
        alu_result = 32'h500; dmem_ready = 1'b1; dmem_rdata = 32'hA5A5A5A5;
        #1;
        check("postreset stall", stall, 32'h0);
        @(posedge clk);
        #1;
        check("postreset wb_read_data", wb_read_data, 32'hA5A5A5A5);
        check("postreset wb_rd", wb_rd, 32'd8);
        check("postreset wb_reg_write", wb_reg_write, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
MEM-stage controller that consumes the EX/MEM pipeline-register outputs and drives the data-memory bus through a req/ready handshake. It stalls the upstream pipeline for wait-stated memory and resolves branches. It traps misaligned or failed accesses by converting them to bubbles. It contains the MEM/WB pipeline register that feeds write-back.

Parameters:
XLEN, 32, data and address width
TIMEOUT, 16, maximum BUSY cycles before a bus-timeout error; 0 disables the timeout

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
alu_result  in  XLEN  EX/MEM alu_result_out (memory address or ALU value)
write_data  in  XLEN  EX/MEM store data
rd  in  5  EX/MEM destination register
zero  in  1  EX/MEM zero flag
pc_branch  in  XLEN  EX/MEM branch target
reg_write, mem_read, mem_write, mem_to_reg, branch  in  1 each  EX/MEM control bits
dmem_req  out  1  bus request
dmem_we  out  1  1 = store, 0 = load
dmem_addr  out  XLEN  word address (equals alu_result)
dmem_wdata  out  XLEN  store data
dmem_ready  in  1  slave completes the access this cycle
dmem_rdata  in  XLEN  load data, valid when dmem_ready=1
dmem_err  in  1  slave error, sampled only when dmem_ready=1
stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
pc_src  out  1  take branch
pc_target  out  XLEN  branch target (equals pc_branch)
wb_read_data  out  XLEN  MEM/WB load data
wb_alu_result  out  XLEN  MEM/WB ALU value
wb_rd  out  5  MEM/WB destination
wb_reg_write  out  1  MEM/WB write enable
wb_mem_to_reg  out  1  MEM/WB mux select
exc_misalign  out  1  one-cycle pulse: misaligned access dropped
exc_bus  out  1  one-cycle pulse: dmem_err or timeout

Behaviour:
- access = mem_read | mem_write. misaligned = access & (alu_result[1:0] != 0).
- FSM states are IDLE and BUSY. Reset puts the FSM in IDLE and clears the wait counter.
- dmem_req = access & ~misaligned, combinational, in both states. dmem_we, dmem_addr and dmem_wdata are combinational passthroughs.
- IDLE with dmem_req=1 and dmem_ready=1: zero-wait completion; stall=0; MEM/WB captures at the next edge; FSM stays in IDLE.
- IDLE with dmem_req=1 and dmem_ready=0: stall=1; FSM goes to BUSY; counter is set to 1.
- BUSY with dmem_ready=1: stall=0; capture; FSM goes to IDLE.
- BUSY with dmem_ready=0: stall=1; counter increments.
- BUSY with counter==TIMEOUT (TIMEOUT≠0) and dmem_ready=0: stall=0; exc_bus=1; bubble captured; FSM goes to IDLE.
- dmem_ready and timeout in the same cycle: dmem_ready wins.
- dmem_ready=1 with dmem_err=1: access completes; exc_bus=1; bubble captured.
- Misaligned access: no request; stall=0; exc_misalign=1; bubble captured.
- EX/MEM inputs are stable while stall=1, because the upstream register is frozen.
- pc_src = branch & zero, combinational. Branches are never memory ops, so pc_src is independent of stall. The flush response is owned by the hazard unit.
- MEM/WB capture, on every edge:
  - Normal capture: wb_alu_result←alu_result, wb_rd←rd, wb_read_data←dmem_rdata when mem_read completes (else holds), wb_reg_write←reg_write, wb_mem_to_reg←mem_to_reg.
  - Bubble: wb_reg_write←0 and wb_mem_to_reg←0; data fields hold.
  - A bubble is inserted on every stall=1 cycle and on every error.
- Reset values: all wb_* = 0; exc_* = 0; FSM in IDLE. This gives dmem_req=stall=0 for zero inputs.
- Reset mid-BUSY: the request drops asynchronously. The slave must tolerate abandoned requests.
- The counter width is clog2(TIMEOUT+1). The counter never wraps; it saturates at TIMEOUT.

Decomposition:
- Shared package riscv_pipe_pkg holds the mem_state_t enum (IDLE, BUSY), the default TIMEOUT, and ALIGN_MASK=2'b11.
- One natural sub-module: mem_wb, the MEM/WB register with load and bubble inputs, instantiated once.

Test Plan:
- Load, zero wait: alu_result=0x100, mem_read=1, reg_write=1, mem_to_reg=1, rd=5; dmem_ready=1, rdata=0xDEADBEEF in the same cycle -> stall stays 0. Next cycle: wb_read_data=0xDEADBEEF, wb_rd=5, wb_reg_write=1.
- Store, 3 wait states: mem_write=1, addr=0x200, wdata=0x1234; dmem_ready rises in the 4th cycle -> dmem_req=1 and dmem_we=1 for 4 cycles, stall=1 for the first 3. wb_reg_write=0 throughout.
- Misaligned load: addr=0x102, mem_read=1 -> dmem_req=0, stall=0, exc_misalign pulses 1 cycle, wb_reg_write=0.
- Timeout with TIMEOUT=4: load with dmem_ready held at 0 -> stall=1 for 4 cycles, then stall=0 and exc_bus=1 for 1 cycle. FSM returns to IDLE; wb_reg_write=0.
- Bus error: load completes with dmem_ready=1, dmem_err=1 -> exc_bus=1, wb_reg_write=0.
- Branch, plus reset mid-access:
  - branch=1, zero=1, pc_branch=0x80 -> pc_src=1, pc_target=0x80 in the same cycle.
  - Assert reset while in BUSY -> dmem_req and stall drop immediately; all wb_* = 0.
